fb_fill_ctrl: RTL and testbench

FB_FILL_CTRL -- requirements
Module: fb_fill_ctrl

---
 rtl/fb_fill_ctrl.sv | 142 ++++++++++++++
 tb/tb_fb_fill_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_fill_ctrl.sv
// rtl/fb_fill_ctrl.sv - rectangle fill engine sharing one framebuffer port with host accesses
module fb_fill_ctrl #(
   parameter int DATA_WIDTH  = 8,
   parameter int COORD_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [COORD_WIDTH-1:0]   cmd_x,
   input  logic [COORD_WIDTH-1:0]   cmd_y,
   input  logic [COORD_WIDTH-1:0]   cmd_w,
   input  logic [COORD_WIDTH-1:0]   cmd_h,
   input  logic [DATA_WIDTH-1:0]    cmd_color,
   input  logic                     host_req,
   input  logic                     host_we,
   input  logic [2*COORD_WIDTH-1:0] host_addr,
   input  logic [DATA_WIDTH-1:0]    host_wdata,
   output logic                     host_ack,
   output logic                     host_rvalid,
   output logic [DATA_WIDTH-1:0]    host_rdata,
   output logic [2*COORD_WIDTH-1:0] mem_addr_a,
   output logic [DATA_WIDTH-1:0]    mem_data_a,
   output logic                     mem_we_a,
   input  logic [DATA_WIDTH-1:0]    mem_q_a,
   output logic                     busy,
   output logic                     done
);

   localparam logic [COORD_WIDTH-1:0] C_ONE = 1;

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic [COORD_WIDTH-1:0]  r_x0, r_y0, r_w, r_h;
   logic [DATA_WIDTH-1:0]   r_color;
   logic [COORD_WIDTH-1:0]  r_cx, r_cy;
   logic                    r_last_fill;
   logic                    r_rvalid;
   logic                    w_host_g, w_fill_g;
   logic                    w_row_end, w_last_px;
   logic [COORD_WIDTH-1:0]  w_px_x, w_px_y;

   // current pixel, wrapping independently in x and y
   assign w_px_x    = r_x0 + r_cx;
   assign w_px_y    = r_y0 + r_cy;
   assign w_row_end = (r_cx == r_w - C_ONE);
   assign w_last_px = w_row_end && (r_cy == r_h - C_ONE);

   // read data is only presented alongside its valid strobe
   assign host_rvalid = r_rvalid;
   assign host_rdata  = r_rvalid ? mem_q_a : '0;

   // state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // next state, arbitration and memory port A drive
   always_comb begin
      w_next     = r_state;
      cmd_ready  = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      w_host_g   = 1'b0;
      w_fill_g   = 1'b0;
      host_ack   = 1'b0;
      mem_addr_a = '0;
      mem_data_a = '0;
      mem_we_a   = 1'b0;
      if (!rst) begin
         // on contention the host wins only if the fill had the port last
         w_host_g = host_req && ((r_state != S_FILL) || r_last_fill);
         w_fill_g = (r_state == S_FILL) && !w_host_g;
         case (r_state)
            S_IDLE: begin
               cmd_ready = 1'b1;
               if (cmd_valid)
                  w_next = ((cmd_w == '0) || (cmd_h == '0)) ? S_DONE : S_FILL;
            end
            S_FILL: begin
               busy = 1'b1;
               if (w_fill_g && w_last_px) w_next = S_DONE;
            end
            S_DONE: begin
               busy   = 1'b1;
               done   = 1'b1;
               w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
         endcase
         if (w_host_g) begin
            host_ack   = 1'b1;
            mem_addr_a = host_addr;
            mem_data_a = host_wdata;
            mem_we_a   = host_we;
         end else if (w_fill_g) begin
            mem_addr_a = {w_px_y, w_px_x};
            mem_data_a = r_color;
            mem_we_a   = 1'b1;
         end
      end
   end

   // command latch, pixel counters, last-grant and read-valid tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         r_x0        <= '0;
         r_y0        <= '0;
         r_w         <= '0;
         r_h         <= '0;
         r_color     <= '0;
         r_cx        <= '0;
         r_cy        <= '0;
         r_last_fill <= 1'b1;
         r_rvalid    <= 1'b0;
      end else begin
         if ((r_state == S_IDLE) && cmd_valid) begin
            r_x0    <= cmd_x;
            r_y0    <= cmd_y;
            r_w     <= cmd_w;
            r_h     <= cmd_h;
            r_color <= cmd_color;
            r_cx    <= '0;
            r_cy    <= '0;
         end else if (w_fill_g) begin
            if (w_row_end) begin
               r_cx <= '0;
               r_cy <= r_cy + C_ONE;
            end else begin
               r_cx <= r_cx + C_ONE;
            end
         end
         if (w_host_g)      r_last_fill <= 1'b0;
         else if (w_fill_g) r_last_fill <= 1'b1;
         r_rvalid <= w_host_g && !host_we;
      end
   end

endmodule

// File: tb/tb_fb_fill_ctrl.sv
// tb/tb_fb_fill_ctrl.sv - self-checking bench for fb_fill_ctrl
module tb_fb_fill_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [7:0]  cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0, cmd_color = '0;
   logic        host_req = 1'b0, host_we = 1'b0;
   logic [15:0] host_addr = '0;
   logic [7:0]  host_wdata = '0;
   logic        host_ack, host_rvalid;
   logic [7:0]  host_rdata;
   logic [15:0] mem_addr_a;
   logic [7:0]  mem_data_a;
   logic        mem_we_a;
   logic [7:0]  mem_q_a = '0;
   logic        busy, done;

   fb_fill_ctrl #(.DATA_WIDTH(8), .COORD_WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_ack(host_ack), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
      .mem_addr_a(mem_addr_a), .mem_data_a(mem_data_a), .mem_we_a(mem_we_a), .mem_q_a(mem_q_a),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // framebuffer: write-through, 1-cycle registered read
   bit [7:0] mem [0:65535];
   always @(posedge clk) begin
      if (mem_we_a) mem[mem_addr_a] <= mem_data_a;
      mem_q_a <= mem[mem_addr_a];
   end

   int total = 0;
   int bad   = 0;

   // reference model state
   bit         m_last_fill = 1'b1;
   bit         m_rd_pend   = 1'b0;
   logic [7:0] m_rd_exp    = '0;

   typedef struct {
      logic [7:0]  x, y, w, h, c;
      int          exp_wr;
      logic [15:0] exp_first, exp_last;
   } vec_t;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // one clock cycle: inputs already applied; compare port A / host outputs to the model
   task automatic tick_check(input bit fill_pend, input logic [15:0] faddr, input logic [7:0] fcol,
                             output bit got_fill, output bit got_host);
      bit eh, ef;
      eh = host_req && (!fill_pend || m_last_fill);
      ef = fill_pend && !eh;
      check("rvalid", host_rvalid, m_rd_pend);
      if (m_rd_pend) check("rdata", host_rdata, m_rd_exp);
      check("host_ack", host_ack, eh);
      if (eh) begin
         check("host_addr", mem_addr_a, host_addr);
         check("host_we", mem_we_a, host_we);
         if (host_we) check("host_wdata", mem_data_a, host_wdata);
      end else if (ef) begin
         check("fill_we", mem_we_a, 1);
         check("fill_addr", mem_addr_a, faddr);
         check("fill_data", mem_data_a, fcol);
      end else begin
         check("nogrant_we", mem_we_a, 0);
      end
      m_rd_pend = eh && !host_we;
      m_rd_exp  = mem[host_addr];
      if (eh)      m_last_fill = 1'b0;
      else if (ef) m_last_fill = 1'b1;
      got_fill = ef;
      got_host = eh;
      @(posedge clk);
   endtask

   task automatic set_host(input int hmode, input int hk);
      case (hmode)
         1: begin
            host_req = 1'b1; host_we = 1'b1;
            host_addr = 16'h9000 + 16'(hk); host_wdata = 8'(hk);
         end
         2: begin
            host_req   = 1'($urandom_range(0, 1));
            host_we    = 1'($urandom_range(0, 1));
            host_addr  = {8'(8'h80 + $urandom_range(0, 8'h6F)), 8'($urandom)};
            host_wdata = 8'($urandom);
         end
         default: host_req = 1'b0;
      endcase
   endtask

   // issue one fill and follow it cycle by cycle until the done pulse
   task automatic run_fill(input logic [7:0] x, y, w, h, c, input int hmode,
                           output int ncyc, output int nwr, output int hk,
                           output logic [15:0] fa, output logic [15:0] la);
      logic [15:0] q[$];
      logic [15:0] all[$];
      logic [7:0]  px, py;
      bit          gf, gh, fin;
      for (int j = 0; j < int'(h); j++)
         for (int i = 0; i < int'(w); i++) begin
            py = y + j[7:0];
            px = x + i[7:0];
            q.push_back({py, px});
         end
      all = q;
      ncyc = 0; nwr = 0; hk = 0; fa = '0; la = '0; fin = 1'b0;
      @(negedge clk);
      cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = c; cmd_valid = 1'b1;
      if (hmode == 2) set_host(2, 0); else host_req = 1'b0;
      #1;
      check("accept_ready", cmd_ready, 1);
      check("accept_busy", busy, 0);
      tick_check(1'b0, 16'h0, c, gf, gh);
      for (int k = 0; k < 300 && !fin; k++) begin
         @(negedge clk);
         cmd_valid = (hmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
         cmd_x = 8'($urandom); cmd_y = 8'($urandom);
         cmd_w = 8'($urandom); cmd_h = 8'($urandom); cmd_color = 8'($urandom);
         set_host(hmode, hk);
         #1;
         check("busy", busy, 1);
         check("cmd_ready_busy", cmd_ready, 0);
         if (q.size() > 0) begin
            check("done_early", done, 0);
            tick_check(1'b1, q[0], c, gf, gh);
            ncyc++;
            if (gf) begin
               if (nwr == 0) fa = q[0];
               la = q[0];
               nwr++;
               void'(q.pop_front());
            end
         end else begin
            check("done_pulse", done, 1);
            tick_check(1'b0, 16'h0, c, gf, gh);
            fin = 1'b1;
         end
         if (gh) hk++;
      end
      if (!fin) check("fill_timeout", 0, 1);
      @(negedge clk);
      cmd_valid = 1'b0; host_req = 1'b0;
      #1;
      check("post_done", done, 0);
      check("post_busy", busy, 0);
      check("post_ready", cmd_ready, 1);
      tick_check(1'b0, 16'h0, c, gf, gh);
      foreach (all[i]) check("fill_mem", mem[all[i]], c);
   endtask

   vec_t        tbl[5];
   int          ncyc, nwr, hk, nw;
   logic [15:0] fa, la;
   bit          gf, gh;

   initial begin
      tbl[0] = '{8'd10,  8'd20,  8'd3, 8'd2, 8'h5A, 6, 16'h140A, 16'h150C};
      tbl[1] = '{8'hFE,  8'hFF,  8'd3, 8'd2, 8'hC3, 6, 16'hFFFE, 16'h0000};
      tbl[2] = '{8'd0,   8'd5,   8'd0, 8'd5, 8'h11, 0, 16'h0000, 16'h0000};
      tbl[3] = '{8'd3,   8'd3,   8'd5, 8'd0, 8'h22, 0, 16'h0000, 16'h0000};
      tbl[4] = '{8'h7F,  8'h30,  8'd1, 8'd1, 8'h99, 1, 16'h307F, 16'h307F};

      // reset state with every request input active
      rst = 1'b1; cmd_valid = 1'b1; cmd_w = 8'd2; cmd_h = 8'd2;
      host_req = 1'b1; host_we = 1'b1; host_addr = 16'hABCD; host_wdata = 8'h77;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_host_ack", host_ack, 0);
      check("rst_we", mem_we_a, 0);
      check("rst_addr", mem_addr_a, 0);
      check("rst_data", mem_data_a, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rvalid", host_rvalid, 0);
      check("rst_rdata", host_rdata, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; cmd_valid = 1'b0; host_req = 1'b0;
      #1;
      check("rel_ready", cmd_ready, 1);
      tick_check(1'b0, 16'h0, 8'h0, gf, gh);

      // table-driven uncontended fills
      foreach (tbl[i]) begin
         run_fill(tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h, tbl[i].c, 0, ncyc, nwr, hk, fa, la);
         check("tbl_cycles", ncyc, tbl[i].exp_wr);
         check("tbl_writes", nwr, tbl[i].exp_wr);
         if (tbl[i].exp_wr > 0) begin
            check("tbl_first", fa, tbl[i].exp_first);
            check("tbl_last", la, tbl[i].exp_last);
         end
      end

      // contention: host writes every cycle of a 4x1 fill
      run_fill(8'h20, 8'h60, 8'd4, 8'd1, 8'hB4, 1, ncyc, nwr, hk, fa, la);
      check("cont_cycles", ncyc, 8);
      check("cont_writes", nwr, 4);
      check("cont_host_cnt", hk, 5);
      for (int k = 0; k < hk; k++) check("cont_host_mem", mem[16'h9000 + 16'(k)], k);

      // host write then read in IDLE
      @(negedge clk);
      host_req = 1'b1; host_we = 1'b1; host_addr = 16'h1234; host_wdata = 8'h34;
      #1;
      tick_check(1'b0, 16'h0, 8'h0, gf, gh);
      @(negedge clk);
      host_we = 1'b0;
      #1;
      check("rd_ack", host_ack, 1);
      check("rd_we", mem_we_a, 0);
      check("rd_addr", mem_addr_a, 16'h1234);
      tick_check(1'b0, 16'h0, 8'h0, gf, gh);
      @(negedge clk);
      host_req = 1'b0;
      #1;
      check("rd_rvalid", host_rvalid, 1);
      check("rd_rdata", host_rdata, 8'h34);
      tick_check(1'b0, 16'h0, 8'h0, gf, gh);
      @(negedge clk); #1;
      check("rd_rvalid_clr", host_rvalid, 0);
      tick_check(1'b0, 16'h0, 8'h0, gf, gh);

      // randomized fills with random host traffic and ignored commands while busy
      for (int r = 0; r < 20; r++)
         run_fill(8'($urandom), 8'($urandom_range(0, 8'h70)), 8'($urandom_range(0, 5)),
                  8'($urandom_range(0, 4)), 8'($urandom), 2, ncyc, nwr, hk, fa, la);

      // reset in the middle of a 4x4 fill
      @(negedge clk);
      cmd_x = 8'h10; cmd_y = 8'hF0; cmd_w = 8'd4; cmd_h = 8'd4; cmd_color = 8'hE7;
      cmd_valid = 1'b1; host_req = 1'b0;
      @(posedge clk);
      nw = 0;
      repeat (2) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         #1;
         if (mem_we_a) nw++;
         @(posedge clk);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_we", mem_we_a, 0);
      check("mid_rst_busy", busy, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_last_fill = 1'b1; m_rd_pend = 1'b0;
      #1;
      check("mid_rel_ready", cmd_ready, 1);
      check("mid_rel_busy", busy, 0);
      repeat (20) begin
         if (mem_we_a) nw++;
         @(negedge clk); #1;
      end
      check("mid_writes", nw, 2);
      check("mid_px0", mem[16'hF010], 8'hE7);
      check("mid_px1", mem[16'hF011], 8'hE7);
      check("mid_px2", mem[16'hF012], 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
